// File: rtl/trng_pool_pkg.sv
// Shared types and parameter defaults for the entropy pool.
// Mode encoding, parameter defaults and a select-width helper.
package trng_pool_pkg;

  typedef enum logic {
    MODE_XOR    = 1'b0,
    MODE_SINGLE = 1'b1
  } mode_e;

  localparam int DEF_N_CH       = 4;
  localparam int DEF_KEY_W      = 32;
  localparam int DEF_DEPTH      = 8;
  localparam int DEF_RCT_CUTOFF = 32;

  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/trng_pool_fifo.sv
// Word FIFO for the entropy pool with registered read data.
// A read on an empty FIFO returns zero without popping.
module trng_pool_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 8,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          rd,
  output logic [W-1:0]  rdata,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          pop;
  logic          wr;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
  assign pop   = rd & ~empty;
  // A full FIFO still takes a write when a pop frees a slot this cycle
  assign wr    = push & (~full | pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      rdata <= '0;
    end else if (clr) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (wr) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + AW'(1);
      end
      if (rd) rdata <= empty ? '0 : mem[rptr];
      if (pop) rptr <= rptr + AW'(1);
      if (wr && !pop) level <= level + LW'(1);
      else if (pop && !wr) level <= level - LW'(1);
    end
  end

endmodule

// File: rtl/trng_pool.sv
// Entropy pool: conditions raw bits into words, health-tests
// the bit stream and buffers finished words for readout.
module trng_pool
  import trng_pool_pkg::*;
#(
  parameter int N_CH       = DEF_N_CH,
  parameter int KEY_W      = DEF_KEY_W,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int RCT_CUTOFF = DEF_RCT_CUTOFF
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         enable_i,
  input  logic                         clr_i,
  input  logic                         mode_i,
  input  logic [sel_w(N_CH)-1:0]       ch_sel_i,
  input  logic                         raw_valid_i,
  input  logic [N_CH-1:0]              raw_bits_i,
  input  logic                         rd_req_i,
  output logic                         rd_valid_o,
  output logic [KEY_W-1:0]             rd_data_o,
  output logic [$clog2(DEPTH+1)-1:0]   level_o,
  input  logic [$clog2(DEPTH+1)-1:0]   thresh_i,
  output logic                         intr_o,
  output logic                         health_fail_o,
  output logic                         overflow_o
);

  localparam int SW   = sel_w(N_CH);
  localparam int LW   = $clog2(DEPTH + 1);
  localparam int CNTW = $clog2(KEY_W + 1);
  localparam int RW   = $clog2(RCT_CUTOFF + 1);
  localparam logic [SW:0] NCH = (SW + 1)'(N_CH);

  mode_e            mode;
  logic [KEY_W-2:0] acc;
  logic [CNTW-1:0]  cnt;
  logic [RW-1:0]    run;
  logic [RW-1:0]    run_nxt;
  logic             prev;
  logic             b;
  logic             accept;
  logic             fail_now;
  logic             done;
  logic             drop;
  logic             rd;
  logic [KEY_W-1:0] word;
  logic             full;
  logic             empty;

  assign mode = mode_e'(mode_i);

  always_comb begin
    b = 1'b0;
    if (mode == MODE_SINGLE) begin
      if ({1'b0, ch_sel_i} < NCH) b = raw_bits_i[ch_sel_i];
      else b = raw_bits_i[0];
    end else begin
      b = ^raw_bits_i;
    end
  end

  // run == 0 marks "no previous bit", so the next bit starts a run of 1
  always_comb begin
    run_nxt = RW'(1);
    if (run != '0 && b == prev) begin
      if (run == RW'(RCT_CUTOFF)) run_nxt = run;
      else run_nxt = run + RW'(1);
    end
  end

  assign accept   = enable_i & raw_valid_i & ~clr_i & ~health_fail_o;
  assign fail_now = accept & (run_nxt == RW'(RCT_CUTOFF));
  assign done     = accept & ~fail_now & (cnt == CNTW'(KEY_W - 1));
  assign word     = {acc, b};
  assign rd       = rd_req_i & ~clr_i;
  assign drop     = done & full & ~(rd_req_i & ~empty);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc           <= '0;
      cnt           <= '0;
      run           <= '0;
      prev          <= 1'b0;
      health_fail_o <= 1'b0;
      overflow_o    <= 1'b0;
      rd_valid_o    <= 1'b0;
    end else if (clr_i) begin
      acc           <= '0;
      cnt           <= '0;
      run           <= '0;
      prev          <= 1'b0;
      health_fail_o <= 1'b0;
      overflow_o    <= 1'b0;
      rd_valid_o    <= 1'b0;
    end else begin
      rd_valid_o <= rd_req_i;
      if (drop) overflow_o <= 1'b1;
      if (!enable_i) begin
        acc  <= '0;
        cnt  <= '0;
        run  <= '0;
        prev <= 1'b0;
      end else if (accept) begin
        prev <= b;
        run  <= run_nxt;
        if (fail_now) begin
          health_fail_o <= 1'b1;
          acc           <= '0;
          cnt           <= '0;
        end else if (done) begin
          acc <= word[KEY_W-2:0];
          cnt <= '0;
        end else begin
          acc <= word[KEY_W-2:0];
          cnt <= cnt + CNTW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) intr_o <= 1'b0;
    else intr_o <= (thresh_i != '0) && (level_o >= thresh_i);
  end

  trng_pool_fifo #(
    .W     (KEY_W),
    .DEPTH (DEPTH),
    .LW    (LW)
  ) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .clr   (clr_i),
    .push  (done),
    .wdata (word),
    .rd    (rd),
    .rdata (rd_data_o),
    .full  (full),
    .empty (empty),
    .level (level_o)
  );

endmodule

// File: doc/trng_pool.md
TRNG_POOL -- requirements
Module: trng_pool

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of raw entropy channels, 1..16.
REQ-002 SHALL have parameter KEY_W, default 32: output word width, 8..64.
REQ-003 SHALL have parameter DEPTH, default 8: FIFO depth in words, power of two, 2..64.
REQ-004 SHALL have parameter RCT_CUTOFF, default 32: repetition-count health-test cutoff, 2..255.
REQ-005 SHALL have port clk_i, input, 1 bit: single clock.
REQ-006 SHALL have port rst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port enable_i, input, 1 bit: sampling enable.
REQ-008 SHALL have port clr_i, input, 1 bit: synchronous clear of FIFO, accumulator, health state and sticky flags.
REQ-009 SHALL have port mode_i, input, 1 bit: 0 XORs all channels; 1 selects a single channel.
REQ-010 SHALL have port ch_sel_i, input, $clog2(N_CH) bits (minimum 1): channel used when mode_i=1.
REQ-011 SHALL have port raw_valid_i, input, 1 bit: raw sample strobe.
REQ-012 SHALL have port raw_bits_i, input, N_CH bits: one raw bit per channel.
REQ-013 SHALL have port rd_req_i, input, 1 bit: read/pop request.
REQ-014 SHALL have port rd_valid_o, output, 1 bit: read response pulse.
REQ-015 SHALL have port rd_data_o, output, KEY_W bits: read data.
REQ-016 SHALL have port level_o, output, $clog2(DEPTH+1) bits: FIFO occupancy.
REQ-017 SHALL have port thresh_i, input, $clog2(DEPTH+1) bits: interrupt threshold.
REQ-018 SHALL have port intr_o, output, 1 bit: level interrupt.
REQ-019 SHALL have port health_fail_o, output, 1 bit: sticky health-test failure.
REQ-020 SHALL have port overflow_o, output, 1 bit: sticky word-dropped flag.

Function
REQ-021 SHALL accept a bit b only in a cycle with enable_i=1, raw_valid_i=1, clr_i=0 and health_fail_o=0.
REQ-022 SHALL form b as the XOR of raw_bits_i when mode_i=0, and as raw_bits_i[ch_sel_i] when mode_i=1; an out-of-range ch_sel_i SHALL select channel 0.
REQ-023 SHALL shift each accepted bit into the accumulator LSB (acc <= {acc[KEY_W-2:0], b}) and increment a bit counter.
REQ-024 SHALL, on acceptance of the KEY_W-th bit, write {acc[KEY_W-2:0], b} into the FIFO at that clock edge if not full, and wrap the bit counter to 0.
REQ-025 SHALL, if the FIFO is full at completion and no pop occurs in the same cycle, drop the word and set overflow_o.
REQ-026 SHALL, when enable_i=0, accept no bits and clear the accumulator and bit counter; FIFO contents are retained.
REQ-027 SHALL implement the repetition count test: run counter set to 1 when b differs from the previous accepted bit, incremented when b equals it, saturating at RCT_CUTOFF.
REQ-028 SHALL treat the first accepted bit after reset, clr_i, or enable_i falling as starting a run of 1.
REQ-029 SHALL, when the run counter reaches RCT_CUTOFF, set health_fail_o at that edge, discard the partial word, write nothing, and accept no further bits until clr_i.
REQ-030 SHALL, on rd_req_i with the FIFO non-empty, pop the oldest word and present it on rd_data_o with a one-cycle rd_valid_o pulse in the next cycle (latency 1).
REQ-031 SHALL, on rd_req_i with the FIFO empty, pulse rd_valid_o in the next cycle with rd_data_o=0 and no pop, even if a push occurs in the same cycle.
REQ-032 SHALL perform both operations when a push and a pop coincide on a full FIFO; level_o is unchanged and overflow_o is not set.
REQ-033 SHALL hold rd_data_o at its last value while rd_valid_o=0.
REQ-034 SHALL drive level_o as the registered occupancy, updated at the push/pop edge.
REQ-035 SHALL drive intr_o high from the cycle after level_o >= thresh_i while thresh_i != 0; thresh_i = 0 SHALL disable intr_o.
REQ-036 SHALL give clr_i priority over every other event: FIFO emptied, accumulator, bit counter, run counter, health_fail_o and overflow_o all cleared, and rd_valid_o=0 in the following cycle.

Reset
REQ-037 SHALL, on rst_ni low, asynchronously set all state and outputs to 0 (rd_valid_o, rd_data_o, level_o, intr_o, health_fail_o, overflow_o, accumulator, counters, FIFO pointers).
REQ-038 SHALL abandon any partial word and any pending read response on reset mid-operation; operation SHALL resume from the first edge after rst_ni deasserts.

Structure
REQ-039 SHALL place the mode encoding (XOR/SINGLE) and the parameter defaults in the shared package trng_pool_pkg.
REQ-040 SHALL implement the FIFO as sub-module trng_pool_fifo (synchronous, registered read data, full/empty/level outputs).
REQ-041 SHALL contain no latches, and all flops SHALL be on clk_i with asynchronous reset rst_ni.

Verification
REQ-042 SHALL cover: KEY_W=32, mode 1, ch 0, alternating pattern 0101… for 32 bits -> one push, 0x55555555 delivered on rd_valid_o one cycle after rd_req_i.
REQ-043 SHALL cover: mode 0, N_CH=4, each sample 4'b0111 -> b=1, causing health_fail_o at the 32nd bit with RCT_CUTOFF=32, level_o staying 0, and no acceptance until clr_i.
REQ-044 SHALL cover: DEPTH=8, nine words produced with no reads -> level_o=8, overflow_o=1, FIFO holding the first eight words in order.
REQ-045 SHALL cover: full FIFO with a word completing in the same cycle as rd_req_i -> level_o stays 8, overflow_o stays 0.
REQ-046 SHALL cover: rd_req_i on an empty FIFO -> rd_valid_o=1 with rd_data_o=0 in the next cycle, and level_o=0.
REQ-047 SHALL cover: thresh_i=3 -> intr_o rising one cycle after level_o becomes 3 and falling one cycle after level_o drops to 2; and rst_ni pulsed after 10 accepted bits -> all outputs 0, with the next word requiring 32 new bits.
